// File: rtl/csi_vc_if.sv
// CSI-2 stream interface: per-virtual-channel frame measurement, framing-error
// status, test-pattern substitution and a two-entry skid buffer on the output.
module csi_vc_if #(
   parameter int DATA_W    = 16,
   parameter int DEST_W    = 4,
   parameter int KEEP_W    = 4,
   parameter int NUM_VC    = 2,
   parameter int GRID_LOG2 = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ibus_cs,
   input  logic              ibus_wr,
   input  logic [7:0]        ibus_addr,
   input  logic [31:0]       ibus_wrdata,
   output logic [31:0]       ibus_rddata,
   output logic              vrst_n,
   input  logic              tvalid_in,
   output logic              tready_in,
   input  logic              tuser_in,
   input  logic              tlast_in,
   input  logic [DATA_W-1:0] tdata_in,
   input  logic [DEST_W-1:0] tdest_in,
   input  logic [KEEP_W-1:0] tkeep_in,
   output logic              tvalid_out,
   input  logic              tready_out,
   output logic              tuser_out,
   output logic              tlast_out,
   output logic [DATA_W-1:0] tdata_out,
   output logic [DEST_W-1:0] tdest_out,
   output logic [KEEP_W-1:0] tkeep_out
);

   localparam int NB = DATA_W / 8;

   logic       ctrl_en;
   logic [2:0] status;
   logic [1:0] vc_sel;
   logic [3:0] ptn_sel;

   logic [15:0] col       [NUM_VC];
   logic [15:0] col_r     [NUM_VC];
   logic [15:0] row       [NUM_VC];
   logic [15:0] row_r     [NUM_VC];
   logic [31:0] frm_len   [NUM_VC];
   logic [31:0] frm_len_r [NUM_VC];
   logic [31:0] frm_cnt   [NUM_VC];

   logic              skid_valid;
   logic              skid_user;
   logic              skid_last;
   logic [DATA_W-1:0] skid_data;
   logic [DEST_W-1:0] skid_dest;
   logic [KEEP_W-1:0] skid_keep;

   logic [5:0]  word;
   logic        bus_we;
   logic        acc;
   logic        in_vc;
   logic [15:0] cur_col;
   logic [15:0] cur_col_r;
   logic [15:0] cur_row;
   logic [31:0] cur_cnt;
   logic [2:0]  status_set;
   logic [2:0]  w1c;
   logic [7:0]  ptn_y;
   logic        use_ptn;
   logic [DATA_W-1:0] in_data;
   logic [31:0] sel_size;
   logic [31:0] sel_len;
   logic [31:0] sel_cnt;
   logic        unused_bits;

   assign word        = ibus_addr[7:2];
   assign bus_we      = ibus_cs & ibus_wr;
   assign tready_in   = ~skid_valid & ~rst;
   assign acc         = tvalid_in & tready_in;
   assign vrst_n      = ctrl_en;
   assign unused_bits = ^{ibus_addr[1:0], ibus_wrdata[31:4]};

   // Pre-update counters of the channel addressed by the incoming beat.
   always_comb begin
      in_vc     = 1'b0;
      cur_col   = '0;
      cur_col_r = '0;
      cur_row   = '0;
      cur_cnt   = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (tdest_in == DEST_W'(i)) begin
            in_vc     = 1'b1;
            cur_col   = col[i];
            cur_col_r = col_r[i];
            cur_row   = row[i];
            cur_cnt   = frm_cnt[i];
         end
      end
   end

   always_comb begin
      status_set = 3'b000;
      if (ctrl_en && acc) begin
         status_set[0] = in_vc & tlast_in & (cur_col_r != 16'd0) & (cur_row != 16'd0)
                         & ((cur_col + 16'd1) != cur_col_r);
         status_set[1] = in_vc & tuser_in & (cur_col != 16'd0);
         status_set[2] = ~in_vc;
      end
      w1c = (bus_we && word == 6'd1) ? ibus_wrdata[2:0] : 3'b000;
   end

   always_comb begin
      ptn_y   = 8'h00;
      use_ptn = 1'b0;
      if (in_vc) begin
         case (ptn_sel)
            4'd1: begin ptn_y = cur_col[7:0]; use_ptn = 1'b1; end
            4'd2: begin ptn_y = cur_row[7:0]; use_ptn = 1'b1; end
            4'd3: begin ptn_y = cur_cnt[7:0]; use_ptn = 1'b1; end
            4'd4: begin
               ptn_y   = (cur_col[GRID_LOG2] ^ cur_row[GRID_LOG2]) ? 8'h00 : 8'hFF;
               use_ptn = 1'b1;
            end
            default: ;
         endcase
      end
      in_data = use_ptn ? {ptn_y, {(NB-1){8'h80}}} : tdata_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_en <= 1'b0;
         status  <= 3'b000;
         vc_sel  <= 2'b00;
         ptn_sel <= 4'h0;
      end else begin
         if (bus_we && word == 6'd0) ctrl_en <= ibus_wrdata[0];
         if (bus_we && word == 6'd2) vc_sel  <= ibus_wrdata[1:0];
         if (bus_we && word == 6'd3) ptn_sel <= ibus_wrdata[3:0];
         status <= (status & ~w1c) | status_set;
      end
   end

   // A disabled interface keeps every measurement at zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_VC; i++) begin
         if (rst || !ctrl_en) begin
            col[i]       <= '0;
            col_r[i]     <= '0;
            row[i]       <= '0;
            row_r[i]     <= '0;
            frm_len[i]   <= '0;
            frm_len_r[i] <= '0;
            frm_cnt[i]   <= '0;
         end else begin
            if (frm_len[i] != 32'hFFFF_FFFF) frm_len[i] <= frm_len[i] + 32'd1;
            if (acc && tdest_in == DEST_W'(i)) begin
               if (tlast_in) begin
                  col[i]   <= '0;
                  col_r[i] <= col[i] + 16'd1;
               end else begin
                  col[i] <= col[i] + 16'd1;
               end
               if (tuser_in) begin
                  row_r[i]     <= row[i];
                  row[i]       <= tlast_in ? 16'd1 : 16'd0;
                  frm_len_r[i] <= frm_len[i];
                  frm_len[i]   <= '0;
                  frm_cnt[i]   <= frm_cnt[i] + 32'd1;
               end else if (tlast_in) begin
                  row[i] <= row[i] + 16'd1;
               end
            end
         end
      end
   end

   // Skid entry drains first so beat order is kept; tready_in already blocks new beats then.
   always_ff @(posedge clk) begin
      if (rst) begin
         tvalid_out <= 1'b0;
         tuser_out  <= 1'b0;
         tlast_out  <= 1'b0;
         tdata_out  <= '0;
         tdest_out  <= '0;
         tkeep_out  <= '0;
         skid_valid <= 1'b0;
         skid_user  <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= '0;
         skid_dest  <= '0;
         skid_keep  <= '0;
      end else if (tready_out || !tvalid_out) begin
         if (skid_valid) begin
            tvalid_out <= 1'b1;
            tuser_out  <= skid_user;
            tlast_out  <= skid_last;
            tdata_out  <= skid_data;
            tdest_out  <= skid_dest;
            tkeep_out  <= skid_keep;
            skid_valid <= 1'b0;
         end else if (acc) begin
            tvalid_out <= 1'b1;
            tuser_out  <= tuser_in;
            tlast_out  <= tlast_in;
            tdata_out  <= in_data;
            tdest_out  <= tdest_in;
            tkeep_out  <= tkeep_in;
         end else begin
            tvalid_out <= 1'b0;
         end
      end else if (acc) begin
         skid_valid <= 1'b1;
         skid_user  <= tuser_in;
         skid_last  <= tlast_in;
         skid_data  <= in_data;
         skid_dest  <= tdest_in;
         skid_keep  <= tkeep_in;
      end
   end

   always_comb begin
      sel_size = '0;
      sel_len  = '0;
      sel_cnt  = '0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (vc_sel == 2'(i)) begin
            sel_size = {row_r[i], col_r[i]};
            sel_len  = frm_len_r[i];
            sel_cnt  = frm_cnt[i];
         end
      end
      ibus_rddata = '0;
      if (ibus_cs) begin
         case (word)
            6'd0:    ibus_rddata = {31'd0, ctrl_en};
            6'd1:    ibus_rddata = {29'd0, status};
            6'd2:    ibus_rddata = {30'd0, vc_sel};
            6'd3:    ibus_rddata = {28'd0, ptn_sel};
            6'd4:    ibus_rddata = sel_size;
            6'd5:    ibus_rddata = sel_len;
            6'd6:    ibus_rddata = sel_cnt;
            default: ibus_rddata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_csi_vc_if.sv
// Directed self-checking bench for csi_vc_if (GRID_LOG2 = 2 so the grid pattern
// toggles every 4 pixels and every 4 lines).
module tb_csi_vc_if;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ibus_cs = 1'b0;
   logic        ibus_wr = 1'b0;
   logic [7:0]  ibus_addr = 8'h00;
   logic [31:0] ibus_wrdata = 32'h0;
   logic [31:0] ibus_rddata;
   logic        vrst_n;
   logic        tvalid_in = 1'b0;
   logic        tready_in;
   logic        tuser_in = 1'b0;
   logic        tlast_in = 1'b0;
   logic [15:0] tdata_in = 16'h0;
   logic [3:0]  tdest_in = 4'h0;
   logic [3:0]  tkeep_in = 4'hF;
   logic        tvalid_out;
   logic        tready_out = 1'b1;
   logic        tuser_out;
   logic        tlast_out;
   logic [15:0] tdata_out;
   logic [3:0]  tdest_out;
   logic [3:0]  tkeep_out;

   int checks = 0;
   int errors = 0;

   localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h04, A_VCSEL = 8'h08,
                          A_PTN = 8'h0C, A_SIZE = 8'h10, A_FLEN = 8'h14, A_FCNT = 8'h18;

   csi_vc_if #(.DATA_W(16), .DEST_W(4), .KEEP_W(4), .NUM_VC(2), .GRID_LOG2(2)) dut (
      .clk(clk), .rst(rst),
      .ibus_cs(ibus_cs), .ibus_wr(ibus_wr), .ibus_addr(ibus_addr),
      .ibus_wrdata(ibus_wrdata), .ibus_rddata(ibus_rddata), .vrst_n(vrst_n),
      .tvalid_in(tvalid_in), .tready_in(tready_in), .tuser_in(tuser_in),
      .tlast_in(tlast_in), .tdata_in(tdata_in), .tdest_in(tdest_in), .tkeep_in(tkeep_in),
      .tvalid_out(tvalid_out), .tready_out(tready_out), .tuser_out(tuser_out),
      .tlast_out(tlast_out), .tdata_out(tdata_out), .tdest_out(tdest_out), .tkeep_out(tkeep_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
      ibus_cs = 1'b1; ibus_wr = 1'b1; ibus_addr = addr; ibus_wrdata = data;
      tick();
      ibus_cs = 1'b0; ibus_wr = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [7:0] addr, input logic [31:0] mask,
                            input logic [31:0] expected);
      logic [31:0] data;
      ibus_cs = 1'b1; ibus_wr = 1'b0; ibus_addr = addr;
      #1;
      data = ibus_rddata;
      ibus_cs = 1'b0;
      checkOutput(tag, data & mask, expected);
      tick();
   endtask

   // One beat, accepted at the next edge; its output must appear right after that edge.
   task automatic applyStimulus(input logic [15:0] data, input logic [3:0] dest,
                                input logic user, input logic last, input logic [15:0] expData);
      int n;
      tvalid_in = 1'b1; tdata_in = data; tdest_in = dest; tuser_in = user; tlast_in = last;
      n = 0;
      while (!tready_in && n < 20) begin tick(); n++; end
      if (n == 20) checkOutput("tready_wait", 32'h0, 32'h1);
      tick();
      tvalid_in = 1'b0; tuser_in = 1'b0; tlast_in = 1'b0;
      checkOutput("beat_valid", 32'(tvalid_out), 32'h1);
      checkOutput("beat_data", 32'(tdata_out), 32'(expData));
      checkOutput("beat_flags", {30'd0, tuser_out, tlast_out}, {30'd0, user, last});
      checkOutput("beat_dest", 32'(tdest_out), 32'(dest));
      checkOutput("beat_keep", 32'(tkeep_out), 32'hF);
   endtask

   initial begin
      logic [15:0] d;
      logic [7:0]  y;
      logic [15:0] expQ [$];
      int k, nOut, held;
      logic sawLow;

      // Reset state
      tick(); tick();
      checkOutput("rst_tready", 32'(tready_in), 32'h0);
      checkOutput("rst_tvalid", 32'(tvalid_out), 32'h0);
      checkOutput("rst_outs", {tdata_out, tdest_out, tkeep_out, 6'd0, tuser_out, tlast_out}, 32'h0);
      checkOutput("rst_vrst", 32'(vrst_n), 32'h0);
      rst = 1'b0;
      tick();
      checkOutput("rel_tready", 32'(tready_in), 32'h1);
      readCheck("rst_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'h0);
      readCheck("rst_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);

      // 1: 4x8 frame on VC0, then start of the next frame
      busWrite(A_CTRL, 32'h1);
      checkOutput("en_vrst", 32'(vrst_n), 32'h1);
      ibus_addr = A_CTRL;
      #1;
      checkOutput("rd_no_cs", ibus_rddata, 32'h0);
      for (int l = 0; l < 4; l++)
         for (int b = 0; b < 8; b++) begin
            d = 16'hA000 | 16'(l << 8) | 16'(b);
            applyStimulus(d, 4'd0, (l == 0 && b == 0), (b == 7), d);
         end
      applyStimulus(16'hB000, 4'd0, 1'b1, 1'b0, 16'hB000);
      readCheck("t1_size", A_SIZE, 32'hFFFF_FFFF, 32'h0004_0008);
      readCheck("t1_fcnt", A_FCNT, 32'hFFFF_FFFF, 32'h2);
      readCheck("t1_flen", A_FLEN, 32'hFFFF_FFFF, 32'd31);
      readCheck("t1_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);

      // 2: column ramp, then grid pattern over an 8x8 frame
      busWrite(A_PTN, 32'h1);
      for (int b = 1; b < 8; b++)
         applyStimulus(16'h1111, 4'd0, 1'b0, (b == 7), 16'(b << 8) | 16'h0080);
      for (int b = 0; b < 8; b++)
         applyStimulus(16'h2222, 4'd0, 1'b0, (b == 7), 16'(b << 8) | 16'h0080);
      busWrite(A_PTN, 32'h4);
      for (int l = 0; l < 8; l++)
         for (int b = 0; b < 8; b++) begin
            y = ((((b >> 2) ^ (l >> 2)) & 1) != 0) ? 8'h00 : 8'hFF;
            applyStimulus(16'h3333, 4'd0, (l == 0 && b == 0), (b == 7), {y, 8'h80});
         end
      busWrite(A_PTN, 32'h0);

      // 3: output stalled for 5 cycles during an 8-beat burst
      k = 0; nOut = 0; held = -1; sawLow = 1'b0;
      for (int t = 0; t < 60 && nOut < 8; t++) begin
         tvalid_in  = (k < 8);
         tdata_in   = 16'hC000 | 16'(k);
         tdest_in   = 4'd0;
         tlast_in   = (k == 7);
         tready_out = (t < 2 || t >= 7);
         #1;
         if (!tready_in && !sawLow) begin sawLow = 1'b1; held = k - nOut; end
         if (tvalid_out && tready_out) begin
            checkOutput("bp_data", 32'(tdata_out), 32'(16'hC000 | 16'(nOut)));
            checkOutput("bp_last", 32'(tlast_out), 32'(nOut == 7));
            nOut++;
         end
         if (tvalid_in && tready_in) k++;
         tick();
      end
      tvalid_in = 1'b0; tlast_in = 1'b0; tready_out = 1'b1;
      checkOutput("bp_stall_seen", 32'(sawLow), 32'h1);
      checkOutput("bp_held", 32'(held), 32'd2);
      checkOutput("bp_count", 32'(nOut), 32'd8);
      tick();
      checkOutput("bp_drained", 32'(tvalid_out), 32'h0);

      // 4: interleaved VC0 (8-beat) and VC1 (6-beat) lines, then an unmeasured VC
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 8; i++) begin
            applyStimulus(16'h4000 | 16'(i), 4'd0, 1'b0, (i == 7), 16'h4000 | 16'(i));
            if (i < 6)
               applyStimulus(16'h5000 | 16'(i), 4'd1, (r == 0 && i == 0), (i == 5), 16'h5000 | 16'(i));
         end
      readCheck("t4_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);
      busWrite(A_VCSEL, 32'h1);
      readCheck("vc1_size", A_SIZE, 32'hFFFF_FFFF, 32'h0000_0006);
      readCheck("vc1_fcnt", A_FCNT, 32'hFFFF_FFFF, 32'h1);
      busWrite(A_VCSEL, 32'h0);
      readCheck("vc0_col", A_SIZE, 32'h0000_FFFF, 32'h8);
      busWrite(A_VCSEL, 32'h2);
      readCheck("vc2_size", A_SIZE, 32'hFFFF_FFFF, 32'h0);
      busWrite(A_VCSEL, 32'h0);
      busWrite(A_PTN, 32'h1);
      applyStimulus(16'h1234, 4'd3, 1'b0, 1'b0, 16'h1234);
      readCheck("badvc_status", A_STATUS, 32'hFFFF_FFFF, 32'h4);
      busWrite(A_STATUS, 32'h4);
      busWrite(A_PTN, 32'h0);

      // 5: short line, W1C, then start of frame mid-line
      for (int b = 0; b < 7; b++)
         applyStimulus(16'h6000, 4'd0, 1'b0, (b == 6), 16'h6000);
      readCheck("len_status", A_STATUS, 32'hFFFF_FFFF, 32'h1);
      busWrite(A_STATUS, 32'h1);
      readCheck("w1c_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);
      for (int b = 0; b < 3; b++)
         applyStimulus(16'h7000, 4'd0, 1'b0, 1'b0, 16'h7000);
      applyStimulus(16'h7001, 4'd0, 1'b1, 1'b0, 16'h7001);
      readCheck("sof_status", A_STATUS, 32'hFFFF_FFFF, 32'h2);

      // 6: reset mid-frame, then enable/disable
      applyStimulus(16'h8000, 4'd0, 1'b0, 1'b0, 16'h8000);
      tvalid_in = 1'b1; tdata_in = 16'h8001; tdest_in = 4'd0;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_tready", 32'(tready_in), 32'h0);
      tick();
      checkOutput("mid_rst_outs", {tdata_out, tdest_out, tkeep_out, 5'd0, tvalid_out, tuser_out, tlast_out}, 32'h0);
      checkOutput("mid_rst_vrst", 32'(vrst_n), 32'h0);
      readCheck("mid_rst_status", A_STATUS, 32'hFFFF_FFFF, 32'h0);
      checkOutput("mid_rst_tready2", 32'(tready_in), 32'h0);
      rst = 1'b0; tvalid_in = 1'b0;
      tick();
      checkOutput("post_rst_tready", 32'(tready_in), 32'h1);
      readCheck("post_rst_ctrl", A_CTRL, 32'hFFFF_FFFF, 32'h0);
      readCheck("post_rst_fcnt", A_FCNT, 32'hFFFF_FFFF, 32'h0);
      busWrite(A_CTRL, 32'h1);
      applyStimulus(16'h9000, 4'd0, 1'b1, 1'b0, 16'h9000);
      applyStimulus(16'h9001, 4'd0, 1'b0, 1'b1, 16'h9001);
      applyStimulus(16'h9002, 4'd0, 1'b1, 1'b0, 16'h9002);
      readCheck("t6_size", A_SIZE, 32'hFFFF_FFFF, 32'h0001_0002);
      readCheck("t6_flen", A_FLEN, 32'hFFFF_FFFF, 32'h1);
      readCheck("t6_fcnt", A_FCNT, 32'hFFFF_FFFF, 32'h2);
      busWrite(A_CTRL, 32'h0);
      checkOutput("dis_vrst", 32'(vrst_n), 32'h0);
      tick();
      readCheck("dis_size", A_SIZE, 32'hFFFF_FFFF, 32'h0);
      readCheck("dis_flen", A_FLEN, 32'hFFFF_FFFF, 32'h0);
      readCheck("dis_fcnt", A_FCNT, 32'hFFFF_FFFF, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csi_vc_if.md
Name: csi_vc_if

Overview:
Parametrised successor to the single-channel CSI stream interface. It sits between the MIPI CSI-2 receiver's AXI-Stream output and the video DMA/processing path. Added over the previous generation:
- per-virtual-channel (tdest) frame format measurement,
- sticky framing-error detection,
- test-pattern substitution with a parametrised grid,
- a 2-entry skid buffer that honours tready_out backpressure.

Parameters:
DATA_W, 16, stream data width; multiple of 8, >=16
DEST_W, 4, tdest width
KEEP_W, 4, tkeep width
NUM_VC, 2, number of measured virtual channels (1..4); tdest values >= NUM_VC are not measured
GRID_LOG2, 6, grid pattern cell size = 2^GRID_LOG2 pixels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ibus_cs  in  1  internal bus select
ibus_wr  in  1  write strobe (qualified by ibus_cs)
ibus_addr  in  8  byte address; word index = ibus_addr[7:2]
ibus_wrdata  in  32  write data
ibus_rddata  out  32  read data, combinational; 0 when ~ibus_cs
vrst_n  out  1  CSI receiver enable = CTRL[0]
tvalid_in / tready_in / tuser_in / tlast_in  in/out/in/in  1  input stream handshake and flags
tdata_in  in  DATA_W  input pixel data
tdest_in  in  DEST_W  input virtual channel
tkeep_in  in  KEEP_W  input byte keep
tvalid_out / tready_out / tuser_out / tlast_out  out/in/out/out  1  output stream handshake and flags
tdata_out  out  DATA_W  output pixel data
tdest_out  out  DEST_W  output virtual channel
tkeep_out  out  KEEP_W  output byte keep

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - CTRL, PTN_SEL, VC_SEL, STATUS, all counters: 0.
  - tvalid_out, tuser_out, tlast_out, tdata_out, tdest_out, tkeep_out: 0.
  - tready_in is 0 while rst=1.
- Register map (word index):
  - 0x0 CTRL: [0] enable, R/W.
  - 0x1 STATUS: sticky, write-1-to-clear.
  - 0x2 VC_SEL: [1:0], R/W.
  - 0x3 PTN_SEL: [3:0], R/W.
  - 0x4 SIZE: {row_r, col_r} of channel VC_SEL, RO.
  - 0x5 FRM_LEN: frm_len_r of channel VC_SEL, RO.
  - 0x6 FRM_CNT: frm_cnt of channel VC_SEL, RO.
  - All other indices read 0; writes to them are ignored.
  - If VC_SEL >= NUM_VC, words 0x4-0x6 read 0.
- Accept: acc = tvalid_in & tready_in. Only accepted beats update counters.
- Skid buffer: output register plus one skid register. tready_in = ~skid_valid (0 in reset).
  - On acc: load the output register when (~tvalid_out | tready_out); otherwise load the skid register.
  - When tready_out=1 and skid_valid=1, the skid entry moves to the output register.
  - Latency: accept to tvalid_out is 1 cycle.
  - No beat is lost or duplicated. Beat order is preserved.
- Per-channel counters, v = tdest_in < NUM_VC:
  - col: 16-bit, increments on each accepted beat; cleared on an accepted tlast beat.
  - col_r: 16-bit, loaded with col+1 on an accepted tlast beat.
  - row: 16-bit, increments on an accepted tlast beat. On an accepted tuser beat, row_r <= row and row <= 0.
    - If tuser and tlast occur on the same beat, row <= 1.
  - frm_len: 32-bit, counts clk cycles since the channel's last accepted tuser and saturates at 0xFFFFFFFF. On an accepted tuser beat, frm_len_r <= frm_len and frm_len <= 0.
  - frm_cnt: 32-bit, increments on an accepted tuser beat and wraps.
  - While CTRL[0]=0, all counters and registered values are held at 0.
- STATUS bits, set only while CTRL[0]=1:
  - [0] line length mismatch: accepted tlast with col+1 != col_r, where col_r != 0 and row != 0.
  - [1] sof mid-line: accepted tuser with col != 0.
  - [2] bad VC: accepted beat with tdest_in >= NUM_VC.
  - If a set event and a W1C on the same bit occur in the same cycle, the set wins.
- Pattern substitution: computed from the channel's pre-update counters at accept time. Y is placed in tdata[DATA_W-1:DATA_W-8]; every other byte is 0x80.
  - PTN_SEL 1: Y = col[7:0].
  - PTN_SEL 2: Y = row[7:0].
  - PTN_SEL 3: Y = frm_cnt[7:0].
  - PTN_SEL 4: Y = (col[GRID_LOG2] ^ row[GRID_LOG2]) ? 0x00 : 0xFF.
  - PTN_SEL 0 or >= 5: pass-through.
  - Unmeasured VCs always pass through.
- tuser, tlast, tdest and tkeep are passed through unchanged with the beat.

Test Plan:
1. Enable; VC0 frame of 4 lines x 8 beats, tready_out=1; second tuser -> SIZE=0x0004_0008, FRM_CNT=2, STATUS=0, each output beat exactly 1 cycle after its accept.
2. PTN_SEL=1 with 8-beat lines -> tdata_out = 0x0080, 0x0180 ... 0x0780 on each line; PTN_SEL=4, GRID_LOG2=2 -> Y toggles 0xFF/0x00 every 4 beats and every 4 lines.
3. tready_out held 0 for 5 cycles during a burst -> tready_in falls after 2 beats are held; on release, all beats emerge in order with no loss or duplication.
4. Interleave VC0 (8-beat lines) and VC1 (6-beat lines) -> VC_SEL=1 reads col 6, VC_SEL=0 reads col 8; a beat with tdest=3 sets STATUS[2] and is passed through unmodified.
5. Line of 7 beats after 8-beat lines -> STATUS[0]=1; write 0x1 to STATUS -> reads 0; tuser at col=3 -> STATUS[1]=1.
6. Assert rst mid-frame -> all outputs and registers read 0, tready_in=0 during reset and 1 the cycle after release; clear CTRL[0] -> vrst_n=0 and counters read 0.
